// File: rtl/dispensador_cafe.sv
// Recipe executor for the coffee machine: runs coffee, milk, foam and sugar phases as a timed
// Moore FSM and hands `listo` back to the selection/payment controller.
module dispensador_cafe #(
  parameter int unsigned T_CAFE   = 4,
  parameter int unsigned T_LECHE  = 3,
  parameter int unsigned T_ESPUMA = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       preparando,
  input  logic [1:0] tamano,
  input  logic       concentracion,
  input  logic       leche,
  input  logic       espuma,
  input  logic [2:0] azucar_anadido,
  output logic       valvula_cafe,
  output logic       valvula_leche,
  output logic       valvula_espuma,
  output logic       dosificador_azucar,
  output logic       ocupado,
  output logic       listo,
  output logic       error
);

  localparam logic [7:0] TCafe   = 8'(T_CAFE);
  localparam logic [7:0] TLeche  = 8'(T_LECHE);
  localparam logic [7:0] TEspuma = 8'(T_ESPUMA);

  typedef enum logic [2:0] {
    StIdle,
    StCafe,
    StLeche,
    StEspuma,
    StAzucar,
    StListo
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] tamano_q;
  logic       conc_q, leche_q, espuma_q;
  logic [2:0] azucar_q;
  logic       prev_q;
  logic       err_q, err_d;
  logic       latch;
  logic       start;
  logic [2:0] azucar_sat;

  function automatic logic [7:0] cafe_len(input logic [1:0] t, input logic c);
    logic [7:0] k;
    logic [7:0] len;
    k   = {6'd0, t} + 8'd1;
    len = TCafe * k;
    return c ? {len[6:0], 1'b0} : len;
  endfunction

  function automatic logic [7:0] leche_len(input logic [1:0] t);
    logic [7:0] k;
    k = {6'd0, t} + 8'd1;
    return TLeche * k;
  endfunction

  assign start      = preparando & ~prev_q;
  assign azucar_sat = (azucar_anadido > 3'd5) ? 3'd5 : azucar_anadido;

  // Phase that follows each stage, skipping disabled ones, with its counter preload.
  state_e     after_cafe, after_leche, after_espuma;
  logic [7:0] load_leche, load_espuma, load_azucar;

  always_comb begin
    after_espuma = (azucar_q != 3'd0) ? StAzucar : StListo;
    after_leche  = espuma_q ? StEspuma : after_espuma;
    after_cafe   = leche_q ? StLeche : after_leche;
    load_leche   = leche_len(tamano_q) - 8'd1;
    load_espuma  = TEspuma - 8'd1;
    load_azucar  = {4'd0, azucar_q, 1'b0} - 8'd1;
  end

  function automatic logic [7:0] load_for(input state_e s, input logic [7:0] ll,
                                          input logic [7:0] le, input logic [7:0] la);
    unique case (s)
      StLeche:  return ll;
      StEspuma: return le;
      StAzucar: return la;
      default:  return 8'd0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    latch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          latch = 1'b1;
          if (tamano == 2'b11) begin
            err_d = 1'b1;
          end else begin
            state_d = StCafe;
            cnt_d   = cafe_len(tamano, concentracion) - 8'd1;
          end
        end
      end
      StCafe: begin
        if (cnt_q == 8'd0) begin
          state_d = after_cafe;
          cnt_d   = load_for(after_cafe, load_leche, load_espuma, load_azucar);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StLeche: begin
        if (cnt_q == 8'd0) begin
          state_d = after_leche;
          cnt_d   = load_for(after_leche, load_leche, load_espuma, load_azucar);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StEspuma: begin
        if (cnt_q == 8'd0) begin
          state_d = after_espuma;
          cnt_d   = load_for(after_espuma, load_leche, load_espuma, load_azucar);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StAzucar: begin
        if (cnt_q == 8'd0) begin
          state_d = StListo;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StListo: begin
        if (!preparando) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      tamano_q <= 2'd0;
      conc_q   <= 1'b0;
      leche_q  <= 1'b0;
      espuma_q <= 1'b0;
      azucar_q <= 3'd0;
      prev_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= preparando;
      err_q   <= err_d;
      if (latch) begin
        tamano_q <= tamano;
        conc_q   <= concentracion;
        leche_q  <= leche;
        espuma_q <= espuma;
        azucar_q <= azucar_sat;
      end
    end
  end

  // Sugar counter starts odd (2n-1), so odd counts mark the first cycle of each dose pair.
  assign valvula_cafe       = (state_q == StCafe);
  assign valvula_leche      = (state_q == StLeche);
  assign valvula_espuma     = (state_q == StEspuma);
  assign dosificador_azucar = (state_q == StAzucar) && cnt_q[0];
  assign ocupado            = (state_q != StIdle);
  assign listo              = (state_q == StListo);
  assign error              = err_q;

endmodule

// File: tb/tb_dispensador_cafe.sv
// Directed self-checking bench for dispensador_cafe: reset, recipes, invalid size and
// reset in the middle of the milk phase.
module tb_dispensador_cafe;

  logic       clk;
  logic       reset;
  logic       preparando;
  logic [1:0] tamano;
  logic       concentracion;
  logic       leche;
  logic       espuma;
  logic [2:0] azucar_anadido;
  logic       valvula_cafe;
  logic       valvula_leche;
  logic       valvula_espuma;
  logic       dosificador_azucar;
  logic       ocupado;
  logic       listo;
  logic       error;

  int n_cmp;
  int n_err;

  dispensador_cafe dut (
    .clk                (clk),
    .reset              (reset),
    .preparando         (preparando),
    .tamano             (tamano),
    .concentracion      (concentracion),
    .leche              (leche),
    .espuma             (espuma),
    .azucar_anadido     (azucar_anadido),
    .valvula_cafe       (valvula_cafe),
    .valvula_leche      (valvula_leche),
    .valvula_espuma     (valvula_espuma),
    .dosificador_azucar (dosificador_azucar),
    .ocupado            (ocupado),
    .listo              (listo),
    .error              (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {valvula_cafe, valvula_leche, valvula_espuma, dosificador_azucar, ocupado, listo,
            error};
  endfunction

  // Runs one drink with preparando held; ec/el/ee are phase lengths, np the expected doses.
  task automatic brew(input string name, input logic [1:0] t, input logic c, input logic l,
                      input logic e, input logic [2:0] a, input int ec, input int el,
                      input int ee, input int np);
    int c_cafe, c_lec, c_esp, c_pul;
    int f_cafe, f_lec, f_esp, f_pul, l_pul;
    int overlap, errs, listo_cyc;
    c_cafe = 0; c_lec = 0; c_esp = 0; c_pul = 0;
    f_cafe = 0; f_lec = 0; f_esp = 0; f_pul = 0; l_pul = 0;
    overlap = 0; errs = 0; listo_cyc = 0;
    @(negedge clk);
    tamano = t; concentracion = c; leche = l; espuma = e; azucar_anadido = a;
    preparando = 1'b1;
    for (int i = 1; i <= 200 && listo_cyc == 0; i++) begin
      @(negedge clk);
      // Recipe inputs must be ignored once latched.
      tamano = 2'($urandom_range(3));
      concentracion = 1'($urandom_range(1));
      leche = 1'($urandom_range(1));
      espuma = 1'($urandom_range(1));
      azucar_anadido = 3'($urandom_range(7));
      if (valvula_cafe) begin c_cafe++; if (f_cafe == 0) f_cafe = i; end
      if (valvula_leche) begin c_lec++; if (f_lec == 0) f_lec = i; end
      if (valvula_espuma) begin c_esp++; if (f_esp == 0) f_esp = i; end
      if (dosificador_azucar) begin c_pul++; if (f_pul == 0) f_pul = i; l_pul = i; end
      if (int'(valvula_cafe) + int'(valvula_leche) + int'(valvula_espuma) > 1) overlap++;
      if (error) errs++;
      if (listo) listo_cyc = i;
    end
    check({name, ".cafe_n"}, c_cafe, ec);
    check({name, ".cafe_first"}, f_cafe, 1);
    check({name, ".leche_n"}, c_lec, el);
    check({name, ".espuma_n"}, c_esp, ee);
    check({name, ".pulsos"}, c_pul, np);
    if (el > 0) check({name, ".leche_first"}, f_lec, 1 + ec);
    if (ee > 0) check({name, ".espuma_first"}, f_esp, 1 + ec + el);
    if (np > 0) begin
      check({name, ".pulso_first"}, f_pul, 1 + ec + el + ee);
      check({name, ".pulso_last"}, l_pul, 1 + ec + el + ee + 2 * (np - 1));
    end
    check({name, ".overlap"}, overlap, 0);
    check({name, ".error"}, errs, 0);
    check({name, ".listo_cyc"}, listo_cyc, 1 + ec + el + ee + 2 * np);
    repeat (2) @(negedge clk);
    check({name, ".listo_held"}, {listo, ocupado}, 2'b11);
    preparando = 1'b0;
    @(negedge clk);
    check({name, ".idle_after"}, {listo, ocupado}, 2'b00);
  endtask

  initial begin
    int lec_seen;
    logic any;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    preparando = 1'b0;
    tamano = 2'd0; concentracion = 1'b0; leche = 1'b0; espuma = 1'b0; azucar_anadido = 3'd0;

    // Reset held for 3 edges with random inputs.
    for (int i = 0; i < 3; i++) begin
      preparando = 1'($urandom_range(1));
      tamano = 2'($urandom_range(3));
      concentracion = 1'($urandom_range(1));
      leche = 1'($urandom_range(1));
      espuma = 1'($urandom_range(1));
      azucar_anadido = 3'($urandom_range(7));
      @(negedge clk);
    end
    check("reset.outs", outs(), 7'd0);
    reset = 1'b1;
    preparando = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.release", outs(), 7'd0);

    brew("negro", 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 4, 0, 0, 0);
    brew("capuchino", 2'b10, 1'b0, 1'b1, 1'b1, 3'd5, 12, 9, 2, 5);
    brew("expreso", 2'b01, 1'b1, 1'b0, 1'b0, 3'd6, 16, 0, 0, 5);

    // Invalid size.
    @(negedge clk);
    tamano = 2'b11; concentracion = 1'b0; leche = 1'b1; espuma = 1'b1; azucar_anadido = 3'd2;
    preparando = 1'b1;
    @(negedge clk);
    check("invalido.error_on", {error, ocupado}, 2'b10);
    any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      any = any | valvula_cafe | valvula_leche | valvula_espuma | dosificador_azucar |
            ocupado | error | listo;
    end
    check("invalido.quiet", any, 1'b0);
    preparando = 1'b0;
    @(negedge clk);
    brew("tras_error", 2'b00, 1'b0, 1'b1, 1'b0, 3'd0, 4, 3, 0, 0);

    // Reset on the third milk cycle, request held high across it.
    @(negedge clk);
    tamano = 2'b01; concentracion = 1'b0; leche = 1'b1; espuma = 1'b0; azucar_anadido = 3'd0;
    preparando = 1'b1;
    lec_seen = 0;
    for (int i = 0; i < 60 && lec_seen < 3; i++) begin
      @(negedge clk);
      if (valvula_leche) lec_seen++;
    end
    check("reset_leche.reached", lec_seen, 3);
    reset = 1'b0;
    @(negedge clk);
    check("reset_leche.outs", {valvula_leche, ocupado, listo}, 3'b000);
    reset = 1'b1;
    @(negedge clk);
    check("reset_leche.restart_held", {valvula_cafe, ocupado}, 2'b11);

    // Reset again with the request dropped: no restart until a fresh rising edge.
    reset = 1'b0;
    preparando = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      any = any | ocupado | valvula_cafe;
    end
    check("reset_bajo.idle", any, 1'b0);
    preparando = 1'b1;
    @(negedge clk);
    check("reset_bajo.restart", {valvula_cafe, ocupado}, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
